// File: rtl/pool_mid_res_buf_ctrl.sv
// Issue/write-back controller around pool_middle_res_upd: reads the stored middle result, issues it to the
// updater, writes each update back and queues window results. Optional err_flag: POOL_MID_RES_BUF_ERR_CHK_EN.
`timescale 1ns/1ps
module pool_mid_res_buf_ctrl #(
  parameter int ADDR_WIDTH     = 6,
  parameter int TAG_FIFO_DEPTH = 8,
  parameter int OUT_FIFO_DEPTH = 8,
  parameter int SIM_DELAY      = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  aclken,
  input  logic [15:0]           s_feat_data,
  input  logic [ADDR_WIDTH-1:0] s_feat_addr,
  input  logic                  s_feat_first,
  input  logic                  s_feat_last,
  input  logic                  s_feat_zero_sfc,
  input  logic                  s_feat_valid,
  output logic                  s_feat_ready,
  output logic [15:0]           pool_upd_in_data,
  output logic [31:0]           pool_upd_in_org_mid_res,
  output logic                  pool_upd_in_is_first_item,
  output logic                  pool_upd_in_is_zero_sfc,
  output logic                  pool_upd_in_valid,
  input  logic [31:0]           pool_upd_out_data,
  input  logic                  pool_upd_out_valid,
  output logic [31:0]           m_res_data,
  output logic [ADDR_WIDTH-1:0] m_res_addr,
  output logic                  m_res_valid,
  input  logic                  m_res_ready
`ifdef POOL_MID_RES_BUF_ERR_CHK_EN
  ,
  output logic                  err_flag
`endif
);

  localparam int TP        = $clog2(TAG_FIFO_DEPTH);
  localparam int OP        = $clog2(OUT_FIFO_DEPTH);
  localparam int CW        = OP + 2;
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

  // Register updates are zero-delay here; SIM_DELAY only keeps the parameter list compatible.
  if (SIM_DELAY < 0) begin : g_sim_delay_unused
  end

  logic [31:0]             ram [RAM_DEPTH];
  logic [31:0]             rd_data;

  logic                    s1_valid;
  logic                    s1_first;
  logic                    s1_zero;
  logic                    s1_last;
  logic [15:0]             s1_data;
  logic [ADDR_WIDTH-1:0]   s1_addr;

  logic [ADDR_WIDTH:0]     tag_mem [TAG_FIFO_DEPTH];
  logic [TP-1:0]           tag_wr_ptr;
  logic [TP-1:0]           tag_rd_ptr;
  logic [TP:0]             tag_cnt;

  logic [ADDR_WIDTH+31:0]  out_mem [OUT_FIFO_DEPTH];
  logic [OP-1:0]           out_wr_ptr;
  logic [OP-1:0]           out_rd_ptr;
  logic [OP:0]             out_cnt;

  logic                    run;
  logic                    hazard;
  logic [CW-1:0]           inflight;
  logic [CW-1:0]           occupancy;
  logic                    accept;
  logic                    tag_push;
  logic                    tag_pop;
  logic                    wb_valid;
  logic                    out_push;
  logic                    out_pop;
  logic [ADDR_WIDTH-1:0]   head_addr;
  logic                    head_last;

  assign head_addr = tag_mem[tag_rd_ptr][ADDR_WIDTH:1];
  assign head_last = tag_mem[tag_rd_ptr][0];

  // An address already in stage 1 or awaiting write-back must not be read again until its update lands.
  always_comb begin
    hazard = s1_valid && (s1_addr == s_feat_addr);
    for (int k = 0; k < TAG_FIFO_DEPTH; k++) begin
      if ((k < int'(tag_cnt)) && (tag_mem[tag_rd_ptr + TP'(k)][ADDR_WIDTH:1] == s_feat_addr)) begin
        hazard = 1'b1;
      end
    end
  end

  assign inflight     = CW'(tag_cnt) + CW'(s1_valid);
  assign occupancy    = inflight + CW'(out_cnt);
  assign s_feat_ready = run && (inflight < CW'(TAG_FIFO_DEPTH))
                            && (occupancy < CW'(OUT_FIFO_DEPTH)) && !hazard;

  assign accept   = aclken && s_feat_valid && s_feat_ready;
  assign tag_push = aclken && s1_valid;
  assign wb_valid = aclken && pool_upd_out_valid;
  assign tag_pop  = wb_valid && (tag_cnt != '0);
  assign out_push = tag_pop && head_last;
  assign out_pop  = aclken && m_res_valid && m_res_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run <= 1'b0;
    end else if (aclken) begin
      run <= 1'b1;
    end
  end

  // Mid-result RAM: write-back port and registered read port (never the same address in one cycle).
  always_ff @(posedge aclk) begin
    if (tag_pop) begin
      ram[head_addr] <= pool_upd_out_data;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_data <= '0;
    end else if (accept) begin
      rd_data <= ram[s_feat_addr];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_zero  <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
      s1_addr  <= '0;
    end else if (aclken) begin
      s1_valid <= accept;
      if (accept) begin
        s1_first <= s_feat_first;
        s1_zero  <= s_feat_zero_sfc;
        s1_last  <= s_feat_last;
        s1_data  <= s_feat_data;
        s1_addr  <= s_feat_addr;
      end
    end
  end

  assign pool_upd_in_valid         = s1_valid;
  assign pool_upd_in_data          = s1_data;
  assign pool_upd_in_org_mid_res   = rd_data;
  assign pool_upd_in_is_first_item = s1_first;
  assign pool_upd_in_is_zero_sfc   = s1_zero;

  always_ff @(posedge aclk) begin
    if (tag_push) begin
      tag_mem[tag_wr_ptr] <= {s1_addr, s1_last};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_cnt    <= '0;
    end else begin
      if (tag_push) begin
        tag_wr_ptr <= tag_wr_ptr + TP'(1);
      end
      if (tag_pop) begin
        tag_rd_ptr <= tag_rd_ptr + TP'(1);
      end
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + (TP+1)'(1);
        2'b01:   tag_cnt <= tag_cnt - (TP+1)'(1);
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (out_push) begin
      out_mem[out_wr_ptr] <= {head_addr, pool_upd_out_data};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_cnt    <= '0;
    end else begin
      if (out_push) begin
        out_wr_ptr <= out_wr_ptr + OP'(1);
      end
      if (out_pop) begin
        out_rd_ptr <= out_rd_ptr + OP'(1);
      end
      case ({out_push, out_pop})
        2'b10:   out_cnt <= out_cnt + (OP+1)'(1);
        2'b01:   out_cnt <= out_cnt - (OP+1)'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // m_res_* follows AXI-Stream rules: the head entry stays put until it is taken.
  assign m_res_valid = (out_cnt != '0);
  assign m_res_data  = m_res_valid ? out_mem[out_rd_ptr][31:0] : '0;
  assign m_res_addr  = m_res_valid ? out_mem[out_rd_ptr][ADDR_WIDTH+31:32] : '0;

`ifdef POOL_MID_RES_BUF_ERR_CHK_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_flag <= 1'b0;
    end else if (wb_valid && (tag_cnt == '0)) begin
      err_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pool_mid_res_buf_ctrl.sv
// Bench for pool_mid_res_buf_ctrl: directed windows, a latency-3 updater model and a per-cycle
// comparison against a memory-level reference of the pooling updates.
`timescale 1ns/1ps
module tb_pool_mid_res_buf_ctrl;
  localparam int AW = 6;
  localparam int W  = AW + 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b1;
  logic          aclken = 1'b1;
  logic [15:0]   s_feat_data = '0;
  logic [AW-1:0] s_feat_addr = '0;
  logic          s_feat_first = 1'b0;
  logic          s_feat_last = 1'b0;
  logic          s_feat_zero_sfc = 1'b0;
  logic          s_feat_valid = 1'b0;
  logic          s_feat_ready;
  logic [15:0]   pool_upd_in_data;
  logic [31:0]   pool_upd_in_org_mid_res;
  logic          pool_upd_in_is_first_item;
  logic          pool_upd_in_is_zero_sfc;
  logic          pool_upd_in_valid;
  logic [31:0]   pool_upd_out_data;
  logic          pool_upd_out_valid;
  logic [31:0]   m_res_data;
  logic [AW-1:0] m_res_addr;
  logic          m_res_valid;
  logic          m_res_ready = 1'b1;
`ifdef POOL_MID_RES_BUF_ERR_CHK_EN
  logic          err_flag;
`endif

  always #5 aclk = ~aclk;

  pool_mid_res_buf_ctrl #(.ADDR_WIDTH(AW), .TAG_FIFO_DEPTH(8), .OUT_FIFO_DEPTH(8), .SIM_DELAY(1)) dut (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken),
    .s_feat_data(s_feat_data), .s_feat_addr(s_feat_addr), .s_feat_first(s_feat_first),
    .s_feat_last(s_feat_last), .s_feat_zero_sfc(s_feat_zero_sfc), .s_feat_valid(s_feat_valid),
    .s_feat_ready(s_feat_ready),
    .pool_upd_in_data(pool_upd_in_data), .pool_upd_in_org_mid_res(pool_upd_in_org_mid_res),
    .pool_upd_in_is_first_item(pool_upd_in_is_first_item), .pool_upd_in_is_zero_sfc(pool_upd_in_is_zero_sfc),
    .pool_upd_in_valid(pool_upd_in_valid),
    .pool_upd_out_data(pool_upd_out_data), .pool_upd_out_valid(pool_upd_out_valid),
    .m_res_data(m_res_data), .m_res_addr(m_res_addr), .m_res_valid(m_res_valid), .m_res_ready(m_res_ready)
`ifdef POOL_MID_RES_BUF_ERR_CHK_EN
    , .err_flag(err_flag)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pooling update applied by the neighbouring updater: accumulate data into the upper half.
  function automatic logic [31:0] upd(input logic first, input logic zero, input logic [31:0] org,
                                      input logic [15:0] d);
    logic [31:0] base;
    base = first ? 32'h0 : org;
    return zero ? base : base + {d, 16'h0};
  endfunction

  // Updater model: fixed latency of 3 enabled cycles, shares aclken, flushed by reset.
  logic [2:0]  uv;
  logic [31:0] ud [3];
  logic        stray = 1'b0;
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      uv <= '0;
    end else if (aclken) begin
      uv    <= {uv[1:0], pool_upd_in_valid};
      ud[0] <= upd(pool_upd_in_is_first_item, pool_upd_in_is_zero_sfc, pool_upd_in_org_mid_res, pool_upd_in_data);
      ud[1] <= ud[0];
      ud[2] <= ud[1];
    end
  end
  assign pool_upd_out_valid = uv[2] | stray;
  assign pool_upd_out_data  = ud[2];

  // Reference: memory of middle results updated in acceptance order, plus expected result stream.
  logic [31:0]  mem_m [64];
  bit           known [64];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] last_res = '0;
  int           res_cnt = 0;
  bit           iss_pend = 0;
  bit           iss_org_chk = 0;
  logic [15:0]  iss_data;
  logic         iss_first, iss_zero;
  logic [31:0]  iss_org;
  bit           hold_prev = 0;
  logic [W-1:0] prev_res;

  always @(negedge aclk) begin
    if (!aresetn) begin
      exp_q.delete();
      iss_pend  = 0;
      hold_prev = 0;
      for (int i = 0; i < 64; i++) known[i] = 0;
    end else begin
      if (iss_pend) begin
        check("issue_valid", pool_upd_in_valid, 1);
        check("issue_data", pool_upd_in_data, iss_data);
        check("issue_first", pool_upd_in_is_first_item, iss_first);
        check("issue_zero", pool_upd_in_is_zero_sfc, iss_zero);
        if (iss_org_chk) check("issue_org", pool_upd_in_org_mid_res, iss_org);
        if (aclken) iss_pend = 0;
      end else begin
        check("issue_idle", pool_upd_in_valid, 0);
      end
      if (s_feat_valid && s_feat_ready && aclken) begin
        logic [31:0] nv;
        iss_pend    = 1;
        iss_data    = s_feat_data;
        iss_first   = s_feat_first;
        iss_zero    = s_feat_zero_sfc;
        iss_org     = mem_m[s_feat_addr];
        iss_org_chk = known[s_feat_addr] && !s_feat_first;
        nv = upd(s_feat_first, s_feat_zero_sfc, mem_m[s_feat_addr], s_feat_data);
        mem_m[s_feat_addr] = nv;
        known[s_feat_addr] = 1;
        if (s_feat_last) exp_q.push_back({s_feat_addr, nv});
      end
      if (hold_prev) begin
        check("m_res_hold_valid", m_res_valid, 1);
        check("m_res_hold_data", {m_res_addr, m_res_data}, prev_res);
      end
      if (m_res_valid && m_res_ready && aclken) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL m_res_unexpected: got %0h expected none", {m_res_addr, m_res_data});
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if ({m_res_addr, m_res_data} !== e) begin
            errors++;
            $display("FAIL m_res: got %0h expected %0h", {m_res_addr, m_res_data}, e);
          end
          last_res = {m_res_addr, m_res_data};
          res_cnt++;
        end
      end
      hold_prev = m_res_valid && !(m_res_ready && aclken);
      prev_res  = {m_res_addr, m_res_data};
    end
  end

  // Presents one item from posedge+1; returns whether it was taken and how many cycles it waited.
  task automatic send(input logic [AW-1:0] a, input logic [15:0] d, input logic f, input logic l,
                      input logic z, input int max_wait, output bit ok, output int stalls);
    s_feat_addr = a; s_feat_data = d; s_feat_first = f; s_feat_last = l; s_feat_zero_sfc = z;
    s_feat_valid = 1'b1;
    ok = 0;
    stalls = 0;
    while (!ok && stalls < max_wait) begin
      @(negedge aclk);
      if (s_feat_ready && aclken) ok = 1;
      else stalls++;
      @(posedge aclk);
      #1;
    end
    s_feat_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge aclk);
      n++;
    end
    #1;
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int st, tot, base;
    #1 aresetn = 1'b0;
    #1;
    check("rst_s_feat_ready", s_feat_ready, 0);
    check("rst_upd_in_valid", pool_upd_in_valid, 0);
    check("rst_m_res_valid", m_res_valid, 0);
    check("rst_m_res_data", m_res_data, 0);
    check("rst_m_res_addr", m_res_addr, 0);
    check("rst_upd_in_data", pool_upd_in_data, 0);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;

    // 1: single-item window
    base = res_cnt;
    send(6'd5, 16'h4000, 1, 1, 0, 50, ok, st);
    check("t1_accept", ok, 1);
    drain("t1");
    check("t1_res_cnt", res_cnt - base, 1);
    check("t1_res", last_res, {6'd5, 32'h4000_0000});

    // 2: same-address read-after-write stall
    send(6'd3, 16'h0100, 1, 0, 0, 50, ok, st);
    check("t2a_accept", ok, 1);
    send(6'd3, 16'h0002, 0, 1, 0, 50, ok, st);
    check("t2b_accept", ok, 1);
    check("t2_stall_cycles", st, 4);
    drain("t2");
    check("t2_res", last_res, {6'd3, 32'h0102_0000});

    // 3: streaming, no stalls expected
    base = res_cnt;
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      send(AW'(i), 16'h1000 + 16'(i), 1, 1, 0, 50, ok, st);
      check("t3_accept", ok, 1);
      tot += st;
    end
    check("t3_stalls", tot, 0);
    drain("t3");
    check("t3_res_cnt", res_cnt - base, 8);
    check("t3_res_last", last_res, {6'd7, 32'h1007_0000});

    // 4: output backpressure fills the credit window
    base = res_cnt;
    m_res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(AW'(8 + i), 16'h2000 + 16'(i), 1, 1, 0, 50, ok, st);
      check("t4_accept", ok, 1);
    end
    send(6'd16, 16'h2008, 1, 1, 0, 20, ok, st);
    check("t4_credit_stall", ok, 0);
    check("t4_buffered_valid", m_res_valid, 1);
    check("t4_ready_low", s_feat_ready, 0);
    m_res_ready = 1'b1;
    for (int i = 8; i < 12; i++) begin
      send(AW'(8 + i), 16'h2000 + 16'(i), 1, 1, 0, 50, ok, st);
      check("t4_accept_rest", ok, 1);
    end
    drain("t4");
    check("t4_res_cnt", res_cnt - base, 12);

    // 5: clock-enable gap in the middle of interleaved windows
    base = res_cnt;
    fork
      begin
        send(6'd20, 16'h0011, 1, 0, 0, 50, ok, st);
        send(6'd21, 16'h0022, 1, 0, 0, 50, ok, st);
        send(6'd20, 16'h0033, 0, 0, 0, 50, ok, st);
        send(6'd21, 16'h0044, 0, 1, 1, 50, ok, st);
        send(6'd20, 16'h0055, 0, 1, 0, 50, ok, st);
        check("t5_accept", ok, 1);
      end
      begin
        repeat (3) @(posedge aclk);
        #1 aclken = 1'b0;
        repeat (5) @(posedge aclk);
        #1 aclken = 1'b1;
      end
    join
    drain("t5");
    check("t5_res_cnt", res_cnt - base, 2);
    check("t5_res", last_res, {6'd20, 32'h0099_0000});

    // 6: reset with updates in flight
    for (int i = 0; i < 4; i++) send(AW'(30 + i), 16'h3000, 1, 1, 0, 50, ok, st);
    #2 aresetn = 1'b0;
    #1;
    check("t6_ready_rst", s_feat_ready, 0);
    check("t6_upd_valid_rst", pool_upd_in_valid, 0);
    check("t6_m_res_valid_rst", m_res_valid, 0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    base = res_cnt;
    send(6'd0, 16'h7000, 1, 1, 0, 50, ok, st);
    check("t6_accept", ok, 1);
    drain("t6");
    check("t6_res_cnt", res_cnt - base, 1);
    check("t6_res", last_res, {6'd0, 32'h7000_0000});

    // 7: stray write-back with nothing in flight
`ifdef POOL_MID_RES_BUF_ERR_CHK_EN
    check("t7_err_clear", err_flag, 0);
`endif
    base = res_cnt;
    @(posedge aclk); #1 stray = 1'b1;
    @(posedge aclk); #1 stray = 1'b0;
`ifdef POOL_MID_RES_BUF_ERR_CHK_EN
    check("t7_err_set", err_flag, 1);
`endif
    repeat (5) @(posedge aclk);
    #1;
    check("t7_no_result", res_cnt - base, 0);
`ifdef POOL_MID_RES_BUF_ERR_CHK_EN
    check("t7_err_sticky", err_flag, 1);
    aresetn = 1'b0;
    #1;
    check("t7_err_reset", err_flag, 0);
    @(posedge aclk); #1 aresetn = 1'b1;
    @(posedge aclk); #1;
`endif
    send(6'd9, 16'h0009, 1, 1, 0, 50, ok, st);
    drain("t7");
    check("t7_res", last_res, {6'd9, 32'h0009_0000});

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
